// File: rtl/ab_cond_pkg.sv
// Shared types and default parameters for the A/B input conditioner.
// Optional glitch counters are enabled with AB_GLITCH_COUNT_EN.
package ab_cond_pkg;

   // Bit 1 of the encoding equals the accepted output level.
   typedef enum logic [1:0] {
      LOW     = 2'b00,
      WAIT_HI = 2'b01,
      HIGH    = 2'b10,
      WAIT_LO = 2'b11
   } deb_state_t;

   localparam int unsigned DEB_CYCLES_DEFAULT = 4;
   localparam int unsigned CNT_W_DEFAULT      = 8;

endpackage

// File: rtl/debounce_chan.sv
// One conditioner channel: two-flop synchroniser, debounce FSM, edge strobes.
// AB_GLITCH_COUNT_EN adds a saturating count of aborted transitions.
module debounce_chan
   import ab_cond_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             raw,
`ifdef AB_GLITCH_COUNT_EN
   input  logic             glitch_clr,
   output logic [CNT_W-1:0] glitch,
`endif
   output logic             out,
   output logic             rise,
   output logic             fall
);

   if (DEB_CYCLES < 1 || (DEB_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
      $error("debounce_chan: DEB_CYCLES must be in 1 .. 2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);
   localparam bit               Direct  = (DEB_CYCLES == 1);

   logic             s1_q, s2_q;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         LOW: begin
            if (s2_q) begin
               if (Direct) begin
                  state_d = HIGH;
                  out_d   = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = WAIT_HI;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         WAIT_HI: begin
            if (!s2_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = HIGH;
               cnt_d   = '0;
               out_d   = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s2_q) begin
               if (Direct) begin
                  state_d = LOW;
                  out_d   = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = WAIT_LO;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         WAIT_LO: begin
            if (s2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = LOW;
               cnt_d   = '0;
               out_d   = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= LOW;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= raw;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign out  = out_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef AB_GLITCH_COUNT_EN
   logic             abort;
   logic [CNT_W-1:0] glitch_q;

   // A WAIT state seeing the current level again means the pulse was too short.
   assign abort = ((state_q == WAIT_HI) && !s2_q) || ((state_q == WAIT_LO) && s2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else if (glitch_clr) begin
         glitch_q <= '0;
      end else if (abort && (glitch_q != '1)) begin
         glitch_q <= glitch_q + CNT_W'(1);
      end
   end

   assign glitch = glitch_q;
`endif

endmodule

// File: rtl/ab_input_conditioner.sv
// Synchronises and debounces the two raw inputs feeding the AND gate.
// AB_GLITCH_COUNT_EN exposes per-channel aborted-transition counters.
module ab_input_conditioner
   import ab_cond_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_raw,
   input  logic             b_raw,
`ifdef AB_GLITCH_COUNT_EN
   input  logic             glitch_clr,
   output logic [CNT_W-1:0] a_glitch,
   output logic [CNT_W-1:0] b_glitch,
`endif
   output logic             a_out,
   output logic             b_out,
   output logic             a_rise,
   output logic             a_fall,
   output logic             b_rise,
   output logic             b_fall
);

   debounce_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_chan_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (a_raw),
`ifdef AB_GLITCH_COUNT_EN
      .glitch_clr (glitch_clr),
      .glitch     (a_glitch),
`endif
      .out        (a_out),
      .rise       (a_rise),
      .fall       (a_fall)
   );

   debounce_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_chan_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (b_raw),
`ifdef AB_GLITCH_COUNT_EN
      .glitch_clr (glitch_clr),
      .glitch     (b_glitch),
`endif
      .out        (b_out),
      .rise       (b_rise),
      .fall       (b_fall)
   );

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Directed bench for ab_input_conditioner at the default DEB_CYCLES=4.
// Output vector order: {a_out, b_out, a_rise, a_fall, b_rise, b_fall}.
module tb_ab_input_conditioner;

   logic clk;
   logic rst_n;
   logic a_raw;
   logic b_raw;
   logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;
   logic gate;
`ifdef AB_GLITCH_COUNT_EN
   logic       glitch_clr;
   logic [7:0] a_glitch, b_glitch;
`endif

   int checks = 0;
   int errors = 0;

   ab_input_conditioner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_raw      (a_raw),
      .b_raw      (b_raw),
`ifdef AB_GLITCH_COUNT_EN
      .glitch_clr (glitch_clr),
      .a_glitch   (a_glitch),
      .b_glitch   (b_glitch),
`endif
      .a_out      (a_out),
      .b_out      (b_out),
      .a_rise     (a_rise),
      .a_fall     (a_fall),
      .b_rise     (b_rise),
      .b_fall     (b_fall)
   );

   assign gate = a_out & b_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [5:0] exp);
      chk(tag, {2'b00, a_out, b_out, a_rise, a_fall, b_rise, b_fall}, {2'b00, exp});
   endtask

   // n edges after the stimulus change the new level must appear; check before, at, after.
   task automatic run(input string tag, input int n, input logic [5:0] pre,
                      input logic [5:0] at, input logic [5:0] post);
      for (int i = 1; i < n; i++) begin
         tick();
         chk_outs({tag, "_wait"}, pre);
      end
      tick();
      chk_outs({tag, "_edge"}, at);
      tick();
      chk_outs({tag, "_after"}, post);
   endtask

   initial begin
      rst_n = 1'b1;
      a_raw = 1'b1;
      b_raw = 1'b1;
`ifdef AB_GLITCH_COUNT_EN
      glitch_clr = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1;
      chk_outs("reset_async", 6'b000000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_outs("reset_hold", 6'b000000);
      end

      // Release with both raw inputs already high.
      rst_n = 1'b1;
      run("release_rise", 6, 6'b000000, 6'b111010, 6'b110000);
      a_raw = 1'b0;
      b_raw = 1'b0;
      run("release_fall", 6, 6'b110000, 6'b000101, 6'b000000);

      // Clean edges on A only.
      a_raw = 1'b1;
      run("clean_rise", 6, 6'b000000, 6'b101000, 6'b100000);
      a_raw = 1'b0;
      run("clean_fall", 6, 6'b100000, 6'b000100, 6'b000000);

      // Three-cycle pulse is one short of acceptance.
      a_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outs("bounce_hi", 6'b000000);
      end
      a_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_outs("bounce_reject", 6'b000000);
      end
`ifdef AB_GLITCH_COUNT_EN
      chk("a_glitch", a_glitch, 8'd1);
      chk("b_glitch", b_glitch, 8'd0);
`endif

      // 1,0,1 chatter then settle high.
      a_raw = 1'b1;
      tick();
      chk_outs("chatter_1", 6'b000000);
      a_raw = 1'b0;
      tick();
      chk_outs("chatter_0", 6'b000000);
      a_raw = 1'b1;
      run("settle_rise", 6, 6'b000000, 6'b101000, 6'b100000);
      a_raw = 1'b0;
      run("settle_fall", 6, 6'b100000, 6'b000100, 6'b000000);

      // Both channels switch together.
      a_raw = 1'b1;
      b_raw = 1'b1;
      run("simul_rise", 6, 6'b000000, 6'b111010, 6'b110000);
      chk("and_out", {7'd0, gate}, 8'd1);
      a_raw = 1'b0;
      b_raw = 1'b0;
      run("simul_fall", 6, 6'b110000, 6'b000101, 6'b000000);
      chk("and_out_low", {7'd0, gate}, 8'd0);

      // Reset in the middle of a pending rise.
      a_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outs("midwait_pre", 6'b000000);
      end
      rst_n = 1'b0;
      #1;
      chk_outs("midwait_rst", 6'b000000);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_outs("midwait_hold", 6'b000000);
      end
`ifdef AB_GLITCH_COUNT_EN
      chk("a_glitch_rst", a_glitch, 8'd0);
`endif
      rst_n = 1'b1;
      run("midwait_rise", 6, 6'b000000, 6'b101000, 6'b100000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
